// File: rtl/leaderboard_ranked.sv
// Two ranked boards of run times: the fast board keeps the DEPTH smallest times and the slow board keeps the DEPTH largest.
// Each accepted time passes through a compare cycle and then a shift/write cycle, which emits one-cycle rank pulses.
module leaderboard_ranked #(
  parameter int unsigned TIME_W = 39,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                stopwatch_mode,
  input  logic                      time_valid,
  input  logic [TIME_W-1:0]         time_in,
  output logic                      in_ready,
  input  logic                      clear,
  output logic [DEPTH*TIME_W-1:0]   fast_board,
  output logic [DEPTH*TIME_W-1:0]   slow_board,
  output logic [CNT_W-1:0]          fast_count,
  output logic [CNT_W-1:0]          slow_count,
  output logic [DEPTH-1:0]          fast_rank_pulse,
  output logic [DEPTH-1:0]          slow_rank_pulse
);

  localparam logic [1:0] MODE_RUN = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    WR
  } state_t;

  state_t                          state;
  logic [TIME_W-1:0]               pend;
  logic [CNT_W-1:0]                pf;
  logic [CNT_W-1:0]                ps;
  logic [CNT_W-1:0]                pf_c;
  logic [CNT_W-1:0]                ps_c;
  logic [DEPTH-1:0][TIME_W-1:0]    fast_q;
  logic [DEPTH-1:0][TIME_W-1:0]    slow_q;
  logic                            accept_c;

  // Entry k sits at [k*TIME_W +: TIME_W], which is exactly the packed array layout.
  assign fast_board = fast_q;
  assign slow_board = slow_q;

  assign accept_c = (state == IDLE) && in_ready && time_valid && !clear
                    && (stopwatch_mode == MODE_RUN) && (time_in != '0);

  // Insertion ranks: ties keep the existing entry ahead of the new time.
  always_comb begin
    pf_c = '0;
    ps_c = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < fast_count) && (fast_q[k] <= pend)) pf_c = pf_c + CNT_W'(1);
      if ((CNT_W'(k) < slow_count) && (slow_q[k] >= pend)) ps_c = ps_c + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      in_ready        <= 1'b1;
      pend            <= '0;
      pf              <= '0;
      ps              <= '0;
      fast_q          <= '0;
      slow_q          <= '0;
      fast_count      <= '0;
      slow_count      <= '0;
      fast_rank_pulse <= '0;
      slow_rank_pulse <= '0;
    end else begin
      fast_rank_pulse <= '0;
      slow_rank_pulse <= '0;
      if (clear) begin
        // Any in-flight time is dropped without a partial write.
        state      <= IDLE;
        in_ready   <= 1'b1;
        fast_q     <= '0;
        slow_q     <= '0;
        fast_count <= '0;
        slow_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept_c) begin
              pend     <= time_in;
              state    <= CMP;
              in_ready <= 1'b0;
            end
          end

          CMP: begin
            pf    <= pf_c;
            ps    <= ps_c;
            state <= WR;
          end

          WR: begin
            if (pf < CNT_W'(DEPTH)) begin
              for (int unsigned k = 1; k < DEPTH; k++) begin
                if (CNT_W'(k) > pf) fast_q[k] <= fast_q[k-1];
              end
              for (int unsigned k = 0; k < DEPTH; k++) begin
                if (CNT_W'(k) == pf) fast_q[k] <= pend;
              end
              if (fast_count < CNT_W'(DEPTH)) fast_count <= fast_count + CNT_W'(1);
              fast_rank_pulse <= DEPTH'(1) << pf;
            end
            if (ps < CNT_W'(DEPTH)) begin
              for (int unsigned k = 1; k < DEPTH; k++) begin
                if (CNT_W'(k) > ps) slow_q[k] <= slow_q[k-1];
              end
              for (int unsigned k = 0; k < DEPTH; k++) begin
                if (CNT_W'(k) == ps) slow_q[k] <= pend;
              end
              if (slow_count < CNT_W'(DEPTH)) slow_count <= slow_count + CNT_W'(1);
              slow_rank_pulse <= DEPTH'(1) << ps;
            end
            state    <= IDLE;
            in_ready <= 1'b1;
          end

          default: begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
